instruction_fetch_unit: RTL and testbench

Fetch stage for one core of the dual-core processor. Holds the program counter and drives the word address into the per-core asynchronous-read instruction ROM. Captures the returned instruction word into the IF/ID pipeline register for decode. Handles stall, flush and branch/jump redirect from the hazard and execute logic.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/instruction_fetch_unit_ifid_register.sv | 39 +++
 rtl/instruction_fetch_unit.sv | 99 +++++++++
 tb/tb_instruction_fetch_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          PC_W      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Contents of the IF/ID pipeline register handed to decode.
    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    // A squashed slot: NOP with zeroed addresses and no valid flag.
    function automatic ifid_t ifid_bubble();
        ifid_t b;
        b.instr    = NOP_INSTR;
        b.pc       = {PC_W{1'b0}};
        b.pc_plus4 = {PC_W{1'b0}};
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_ifid_register.sv
// IF/ID pipeline register with reset, squash (bubble), load and hold.
module ifid_register
    import fetch_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  logic  squash,
    input  ifid_t d,
    output ifid_t q
);

    ifid_t ifid_d;
    ifid_t ifid_q;

    // Squash wins over load; with neither, the register holds its contents.
    always_comb begin
        ifid_d = ifid_q;
        if (squash) begin
            ifid_d = ifid_bubble();
        end else if (load) begin
            ifid_d = d;
        end else begin
            ifid_d = ifid_q;
        end
    end

    // Register update with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_q <= ifid_bubble();
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign q = ifid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: program counter, next-PC selection, misaligned-redirect flag,
// fetched-instruction counter, and the IF/ID register feeding decode.
module instruction_fetch_unit
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_q;
    logic            misalign_d;
    logic            misalign_q;
    logic [31:0]     fetch_count_d;
    logic [31:0]     fetch_count_q;
    logic            ifid_load_s;
    logic            ifid_squash_s;
    ifid_t           ifid_in_s;
    ifid_t           ifid_out_s;

    // Next-state selection: redirect over flush over stall over advance.
    // Redirect and flush both discard the word currently on the ROM bus.
    always_comb begin
        pc_d          = pc_q;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q;
        ifid_load_s   = 1'b0;
        ifid_squash_s = 1'b0;
        if (redirect_valid) begin
            pc_d          = {redirect_pc[31:2], 2'b00};
            misalign_d    = misalign_q | (redirect_pc[1:0] != 2'b00);
            ifid_squash_s = 1'b1;
        end else if (flush) begin
            ifid_squash_s = 1'b1;
            if (stall) begin
                pc_d = pc_q;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d          = pc_q + 32'd4;
            ifid_load_s   = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // Word captured on advance: ROM data plus the address it came from.
    always_comb begin
        ifid_in_s.instr    = imem_rdata;
        ifid_in_s.pc       = pc_q;
        ifid_in_s.pc_plus4 = pc_q + 32'd4;
        ifid_in_s.valid    = 1'b1;
    end

    // PC, sticky misalign flag and fetch counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    ifid_register u_ifid (
        .clk    (clk),
        .reset  (reset),
        .load   (ifid_load_s),
        .squash (ifid_squash_s),
        .d      (ifid_in_s),
        .q      (ifid_out_s)
    );

    assign imem_addr     = pc_q;
    assign ifid_instr    = ifid_out_s.instr;
    assign ifid_pc       = ifid_out_s.pc;
    assign ifid_pc_plus4 = ifid_out_s.pc_plus4;
    assign ifid_valid    = ifid_out_s.valid;
    assign misalign_err  = misalign_q;
    assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4, fetch_count;
    logic        ifid_valid, misalign_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] rom [128];

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_ipc, m_pp4, m_cnt;
    logic        m_valid, m_mis;

    always #5 clk = ~clk;

    // ROM indexes addr>>2 and wraps every 512 bytes
    assign imem_rdata = rom[imem_addr[8:2]];

    instruction_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .ifid_valid     (ifid_valid),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    // Drive one cycle of inputs, take the edge, update the model, settle.
    task automatic step(input logic r, input logic rv, input logic [31:0] rp,
                        input logic f, input logic s);
        logic [31:0] word;
        reset = r; redirect_valid = rv; redirect_pc = rp; flush = f; stall = s;
        word = rom[(m_pc / 32'd4) % 32'd128];
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_pp4 = 32'h0;
            m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
        end else if (rv) begin
            m_pc = rp - (rp % 32'd4);
            if ((rp % 32'd4) != 32'd0) m_mis = 1'b1;
            m_instr = 32'h0; m_ipc = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
        end else if (f) begin
            m_instr = 32'h0; m_ipc = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
            if (!s) m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_instr = word; m_ipc = m_pc; m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
            m_cnt = m_cnt + 32'd1;
            m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", imem_addr, 32'h0); end
        checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=%h", ifid_instr, 32'h0); end
        checks++; if (ifid_pc !== 32'h0 || ifid_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_ifid_pc got=%h/%h exp=0/0", ifid_pc, ifid_pc_plus4); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", fetch_count); end
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            checks++; if (ifid_instr !== 32'h1000_0000 + i) begin errors++; $display("FAIL run_instr%0d got=%h exp=%h", i, ifid_instr, 32'h1000_0000 + i); end
            checks++; if (ifid_pc !== 4 * i || ifid_pc_plus4 !== 4 * i + 4 || ifid_valid !== 1'b1) begin errors++; $display("FAIL run_pc%0d got=%h/%h/%b exp=%h", i, ifid_pc, ifid_pc_plus4, ifid_valid, 4 * i); end
            checks++; if (fetch_count !== i + 1) begin errors++; $display("FAIL run_count%0d got=%0d exp=%0d", i, fetch_count, i + 1); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] h_instr, h_pc, h_cnt;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);   // pc now 0x10
        h_instr = ifid_instr; h_pc = ifid_pc; h_cnt = fetch_count;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL stall_addr%0d got=%h exp=%h", i, imem_addr, 32'h10); end
            checks++; if (ifid_instr !== h_instr || ifid_pc !== h_pc || fetch_count !== h_cnt || ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got=%h/%h/%0d exp=%h/%h/%0d", i, ifid_instr, ifid_pc, fetch_count, h_instr, h_pc, h_cnt); end
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (ifid_instr !== rom[4] || ifid_pc !== 32'h10) begin errors++; $display("FAIL stall_release got=%h@%h exp=%h@10", ifid_instr, ifid_pc, rom[4]); end
    endtask

    task automatic test_redirect();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);   // pc now 0x08
        step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
        checks++; if (imem_addr !== 32'h40 || ifid_valid !== 1'b0) begin errors++; $display("FAIL redir_first got=%h/%b exp=40/0", imem_addr, ifid_valid); end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (ifid_instr !== rom[16] || ifid_pc !== 32'h40 || ifid_valid !== 1'b1) begin errors++; $display("FAIL redir_second got=%h@%h exp=%h@40", ifid_instr, ifid_pc, rom[16]); end
    endtask

    task automatic test_misalign();
        logic s, f;
        step(1'b0, 1'b1, 32'h43, 1'b1, 1'b1);
        checks++; if (imem_addr !== 32'h40 || misalign_err !== 1'b1 || ifid_valid !== 1'b0) begin errors++; $display("FAIL misalign got=%h/%b/%b exp=40/1/0", imem_addr, misalign_err, ifid_valid); end
        for (int i = 0; i < 10; i++) begin
            s = 1'($urandom_range(0, 1)); f = 1'($urandom_range(0, 1));
            step(1'b0, 1'b0, 32'h0, f, s);
            checks++; if (misalign_err !== 1'b1 || imem_addr !== m_pc) begin errors++; $display("FAIL misalign_sticky%0d got=%b/%h exp=1/%h", i, misalign_err, imem_addr, m_pc); end
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (imem_addr !== 32'h0 || ifid_pc_plus4 !== 32'h0 || ifid_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap got=%h/%h/%h exp=0/0/fffffffc", imem_addr, ifid_pc_plus4, ifid_pc); end
        checks++; if (ifid_instr !== rom[127]) begin errors++; $display("FAIL wrap_instr got=%h exp=%h", ifid_instr, rom[127]); end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if (imem_addr !== 32'h0 || ifid_valid !== 1'b0 || misalign_err !== 1'b0 || fetch_count !== 32'h0 || ifid_pc !== 32'h0) begin errors++; $display("FAIL midreset got=%h/%b/%b/%0d exp=0/0/0/0", imem_addr, ifid_valid, misalign_err, fetch_count); end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (ifid_instr !== rom[0] || ifid_valid !== 1'b1 || fetch_count !== 32'h1) begin errors++; $display("FAIL midreset_first got=%h/%b/%0d exp=%h/1/1", ifid_instr, ifid_valid, fetch_count, rom[0]); end
    endtask

    task automatic test_random();
        logic r, rv, f, s;
        logic [31:0] rp;
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            rv = ($urandom_range(0, 7) == 0);
            f  = ($urandom_range(0, 5) == 0);
            s  = ($urandom_range(0, 4) == 0);
            rp = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'h0000_03FC);
            step(r, rv, rp, f, s);
            checks++;
            if (imem_addr !== m_pc || ifid_instr !== m_instr || ifid_pc !== m_ipc ||
                ifid_pc_plus4 !== m_pp4 || ifid_valid !== m_valid ||
                misalign_err !== m_mis || fetch_count !== m_cnt) begin
                errors++;
                $display("FAIL random%0d got=%h %h %h %h %b %b %0d exp=%h %h %h %h %b %b %0d", i,
                         imem_addr, ifid_instr, ifid_pc, ifid_pc_plus4, ifid_valid, misalign_err, fetch_count,
                         m_pc, m_instr, m_ipc, m_pp4, m_valid, m_mis, m_cnt);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 32'h1000_0000 + i;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_pp4 = 32'h0;
        m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
        @(negedge clk);
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_misalign();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
